// File: rtl/targ_pred_upd_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : targ_pred_upd_ctrl_pkg
// Purpose  : Shared types and constants for the BTB update/maintenance
//            controller (FSM states, write-port and feedback bundles).
// Revision : 1.0 - initial release
// ============================================================================
package targ_pred_upd_ctrl_pkg;

    // Default geometry; the struct field widths below track these values.
    localparam int c_addr_width = 32;
    localparam int c_table_size = 32;
    localparam int c_idx_width  = $clog2(c_table_size);

    // Controller mode: clearing the table, or servicing branch feedback.
    typedef enum logic [0:0] {
        ST_SWEEP = 1'b0,
        ST_RUN   = 1'b1
    } targ_pred_state_e;

    // One request on the BTB write port.
    typedef struct packed {
        logic                    en;
        logic [c_idx_width-1:0]  idx;
        logic [c_addr_width-1:0] targ;
        logic                    vld;
    } targ_pred_wr_t;

    // One resolved-branch feedback item.
    typedef struct packed {
        logic                    valid;
        logic [c_addr_width-1:0] addr;
        logic [c_addr_width-1:0] targ;
    } targ_pred_fb_t;

    // Idle write port: no request, all fields zero.
    localparam targ_pred_wr_t targ_pred_wr_rst = '0;

endpackage : targ_pred_upd_ctrl_pkg
`default_nettype wire

// File: rtl/targ_pred_upd_ctrl_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Round-robin one-hot arbiter. The search starts at a rotating
//            pointer that moves just past the winner after every grant.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] grant
);

    localparam int c_ptr_w = (N > 1) ? $clog2(N) : 1;

    logic [c_ptr_w-1:0] r_ptr;
    logic [c_ptr_w-1:0] w_next_ptr;
    logic [N-1:0]       w_rot;
    logic               w_found;
    int                 w_sel;

    // Rotate requests so bit 0 is the pipe at the pointer, take the first
    // set bit, then map it back to an absolute pipe number.
    always_comb begin
        w_rot   = N'({req, req} >> r_ptr);
        w_found = 1'b0;
        w_sel   = 0;
        grant   = '0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_sel   = int'(r_ptr) + k;
            end
        end
        if (w_sel >= N) begin
            w_sel = w_sel - N;
        end
        for (int i = 0; i < N; i++) begin
            if (en && w_found && (i == w_sel)) begin
                grant[i] = 1'b1;
            end
        end
        w_next_ptr = (w_sel == N - 1) ? '0 : c_ptr_w'(w_sel + 1);
    end

    // Pointer advances only when a grant is actually issued.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (en && w_found) begin
            r_ptr <= w_next_ptr;
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/targ_pred_upd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : targ_pred_upd_ctrl
// Purpose  : BTB update/maintenance controller. Arbitrates execute-pipe
//            branch feedback through a small queue onto the single BTB write
//            port, and runs the table-clear sweep after reset and on flush
//            while holding the predictor disabled.
// Revision : 1.0 - initial release
// ============================================================================
module targ_pred_upd_ctrl
    import targ_pred_upd_ctrl_pkg::*;
#(
    parameter int S_PIPE_CNT = 3,
    parameter int TABLE_SIZE = c_table_size,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_WIDTH = c_addr_width
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush,
    input  logic [S_PIPE_CNT-1:0]                 fb_valid,
    input  logic [S_PIPE_CNT-1:0][ADDR_WIDTH-1:0] fb_addr,
    input  logic [S_PIPE_CNT-1:0][ADDR_WIDTH-1:0] fb_targ,
    output logic [S_PIPE_CNT-1:0]                 fb_ready,
    output logic                                  wr_en,
    input  logic                                  wr_ready,
    output logic [$clog2(TABLE_SIZE)-1:0]         wr_idx,
    output logic [ADDR_WIDTH-1:0]                 wr_targ,
    output logic                                  wr_vld,
    output logic                                  pred_en,
    output logic                                  busy
);

    localparam int                 c_idx_w    = $clog2(TABLE_SIZE);
    localparam int                 c_ptr_w    = $clog2(FIFO_DEPTH);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(TABLE_SIZE - 1);
    localparam logic [c_ptr_w:0]   c_full_cnt = (c_ptr_w + 1)'(FIFO_DEPTH);

    targ_pred_state_e    r_state;
    targ_pred_state_e    w_next_state;
    logic [c_idx_w-1:0]  r_sweep_idx;

    logic [c_idx_w-1:0]    r_q_idx  [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] r_q_targ [FIFO_DEPTH];
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w:0]      r_count;

    logic                  w_run;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_arb_en;
    logic [S_PIPE_CNT-1:0] w_grant;
    targ_pred_fb_t         w_fb;
    targ_pred_wr_t         w_wr;
    logic                  w_unused_addr_bits;

    assign w_run   = rst && (r_state == ST_RUN);
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_full_cnt);

    // A flush cycle drops the in-flight write and blocks new accepts, so the
    // queue can simply be zeroed at the edge.
    assign w_pop    = w_run && !w_empty && wr_ready && !flush;
    assign w_arb_en = w_run && !flush && (!w_full || w_pop);

    rr_arbiter #(
        .N (S_PIPE_CNT)
    ) u_rr_arbiter (
        .clk   (clk),
        .rst   (rst),
        .req   (fb_valid),
        .en    (w_arb_en),
        .grant (w_grant)
    );

    assign fb_ready = w_grant;

    // Select the granted pipe's feedback as the item to enqueue.
    always_comb begin
        w_fb = '0;
        for (int i = 0; i < S_PIPE_CNT; i++) begin
            if (w_grant[i]) begin
                w_fb.valid = 1'b1;
                w_fb.addr  = fb_addr[i];
                w_fb.targ  = fb_targ[i];
            end
        end
    end

    assign w_push             = w_fb.valid;
    assign w_unused_addr_bits = ^w_fb.addr[c_addr_width-1:c_idx_w];

    // Queue storage; only written on an accepted feedback item.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_idx[r_wr_ptr]  <= w_fb.addr[c_idx_w-1:0];
            r_q_targ[r_wr_ptr] <= w_fb.targ;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally (power-of-two).
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sweep index: restart on flush, advance on each accepted clear write.
    // It wraps to 0 on the final write so the next sweep starts clean.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            r_sweep_idx <= '0;
        end else if ((r_state == ST_SWEEP) && wr_ready) begin
            r_sweep_idx <= r_sweep_idx + 1'b1;
        end
    end

    // Mode register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_SWEEP;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next mode and write-port / status outputs.
    always_comb begin
        w_next_state = r_state;
        w_wr         = targ_pred_wr_rst;
        pred_en      = 1'b0;
        busy         = 1'b1;
        case (r_state)
            ST_SWEEP: begin
                if (!flush && wr_ready && (r_sweep_idx == c_last_idx)) begin
                    w_next_state = ST_RUN;
                end
                if (rst) begin
                    w_wr.en  = 1'b1;
                    w_wr.idx = r_sweep_idx;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    w_next_state = ST_SWEEP;
                end
                if (rst) begin
                    w_wr.en   = !w_empty;
                    w_wr.idx  = r_q_idx[r_rd_ptr];
                    w_wr.targ = r_q_targ[r_rd_ptr];
                    w_wr.vld  = 1'b1;
                    pred_en   = 1'b1;
                    busy      = 1'b0;
                end
            end
            default: begin
                w_next_state = ST_SWEEP;
            end
        endcase
    end

    assign wr_en   = w_wr.en;
    assign wr_idx  = w_wr.idx;
    assign wr_targ = w_wr.targ;
    assign wr_vld  = w_wr.vld;

endmodule : targ_pred_upd_ctrl
`default_nettype wire

// File: tb/tb_targ_pred_upd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_targ_pred_upd_ctrl
// Purpose  : Self-checking bench for targ_pred_upd_ctrl with a queue-based
//            reference model of the sweep, arbitration and update queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_targ_pred_upd_ctrl;

    localparam int NP = 3;
    localparam int TS = 32;
    localparam int FD = 4;
    localparam int AW = 32;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  flush;
    logic [NP-1:0]         fb_valid;
    logic [NP-1:0][AW-1:0] fb_addr;
    logic [NP-1:0][AW-1:0] fb_targ;
    logic [NP-1:0]         fb_ready;
    logic                  wr_en;
    logic                  wr_ready;
    logic [4:0]            wr_idx;
    logic [AW-1:0]         wr_targ;
    logic                  wr_vld;
    logic                  pred_en;
    logic                  busy;

    targ_pred_upd_ctrl #(
        .S_PIPE_CNT (NP),
        .TABLE_SIZE (TS),
        .FIFO_DEPTH (FD),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .fb_valid (fb_valid),
        .fb_addr  (fb_addr),
        .fb_targ  (fb_targ),
        .fb_ready (fb_ready),
        .wr_en    (wr_en),
        .wr_ready (wr_ready),
        .wr_idx   (wr_idx),
        .wr_targ  (wr_targ),
        .wr_vld   (wr_vld),
        .pred_en  (pred_en),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int hs_cnt   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode flag, sweep position, rr pointer, FIFO as a queue.
    typedef struct {
        int          idx;
        logic [31:0] targ;
    } ent_t;

    ent_t mq[$];
    bit   m_sweep = 1'b1;
    int   m_sidx  = 0;
    int   m_ptr   = 0;

    task automatic rand_data();
        for (int i = 0; i < NP; i++) begin
            fb_addr[i] = $urandom;
            fb_targ[i] = $urandom;
        end
    endtask

    // One clock: check outputs mid-cycle against the model, then advance it.
    task automatic cycle();
        int            e_grant;
        bit            e_pop;
        bit            e_en;
        logic [NP-1:0] e_ready;
        e_grant = -1;
        e_pop   = 1'b0;
        @(negedge clk);
        if (|(fb_valid & fb_ready)) hs_cnt++;
        if (!rst) begin
            check_eq("rst_wr_en", wr_en, 0);
            check_eq("rst_fb_ready", fb_ready, 0);
            check_eq("rst_pred_en", pred_en, 0);
            check_eq("rst_busy", busy, 1);
        end else if (m_sweep) begin
            check_eq("sw_wr_en", wr_en, 1);
            check_eq("sw_wr_idx", wr_idx, m_sidx);
            check_eq("sw_wr_targ", wr_targ, 0);
            check_eq("sw_wr_vld", wr_vld, 0);
            check_eq("sw_fb_ready", fb_ready, 0);
            check_eq("sw_pred_en", pred_en, 0);
            check_eq("sw_busy", busy, 1);
        end else begin
            e_en = (mq.size() > 0);
            check_eq("run_wr_en", wr_en, e_en);
            if (e_en) begin
                check_eq("run_wr_idx", wr_idx, mq[0].idx);
                check_eq("run_wr_targ", wr_targ, mq[0].targ);
                check_eq("run_wr_vld", wr_vld, 1);
            end
            check_eq("run_pred_en", pred_en, 1);
            check_eq("run_busy", busy, 0);
            e_pop = e_en && wr_ready && !flush;
            if (!flush && (mq.size() < FD || e_pop)) begin
                for (int k = 0; k < NP; k++) begin
                    if (e_grant < 0 && fb_valid[(m_ptr + k) % NP]) e_grant = (m_ptr + k) % NP;
                end
            end
            e_ready = (e_grant >= 0) ? NP'(1 << e_grant) : '0;
            check_eq("run_fb_ready", fb_ready, e_ready);
        end
        @(posedge clk);
        if (!rst) begin
            mq.delete();
            m_sweep = 1'b1;
            m_sidx  = 0;
            m_ptr   = 0;
        end else if (m_sweep) begin
            if (flush) begin
                m_sidx = 0;
            end else if (wr_ready) begin
                if (m_sidx == TS - 1) begin
                    m_sweep = 1'b0;
                    m_sidx  = 0;
                end else begin
                    m_sidx++;
                end
            end
        end else if (flush) begin
            mq.delete();
            m_sweep = 1'b1;
            m_sidx  = 0;
        end else begin
            if (e_pop) void'(mq.pop_front());
            if (e_grant >= 0) begin
                mq.push_back('{int'(fb_addr[e_grant][4:0]), fb_targ[e_grant]});
                m_ptr = (e_grant + 1) % NP;
            end
        end
        #1;
    endtask

    initial begin
        int cyc;
        rst      = 1'b0;
        flush    = 1'b0;
        wr_ready = 1'b1;
        fb_valid = '0;
        rand_data();
        @(posedge clk);
        #1;
        cycle();
        cycle();

        // Release reset: full sweep with the write port always free.
        rst = 1'b1;
        fb_valid = '1;
        for (int c = 0; c < TS; c++) begin
            rand_data();
            cycle();
        end

        // All pipes requesting, write port free: round-robin 0,1,2,...
        for (int c = 0; c < 20; c++) begin
            rand_data();
            cycle();
        end

        // Drain, then stall the write port with pipe 1 requesting.
        fb_valid = '0;
        for (int c = 0; c < 8; c++) cycle();
        fb_valid = 3'b010;
        wr_ready = 1'b0;
        hs_cnt   = 0;
        for (int c = 0; c < 6; c++) begin
            rand_data();
            cycle();
        end
        check_eq("stall_accepts", hs_cnt, 4);
        wr_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            rand_data();
            cycle();
        end

        // Queue three entries, flush, then sweep with a toggling write port.
        fb_valid = '0;
        for (int c = 0; c < 8; c++) cycle();
        wr_ready = 1'b0;
        fb_valid = '1;
        for (int c = 0; c < 3; c++) begin
            rand_data();
            cycle();
        end
        fb_valid = '0;
        flush    = 1'b1;
        wr_ready = 1'b1;
        cycle();
        flush = 1'b0;
        cyc   = 0;
        while (m_sweep && cyc < 200) begin
            wr_ready = cyc[0] ? 1'b0 : 1'b1;
            fb_valid = NP'($urandom);
            rand_data();
            cycle();
            cyc++;
        end
        check_eq("toggle_sweep_done", pred_en, 1);

        // Mid-sweep reset at index 17.
        wr_ready = 1'b1;
        flush    = 1'b1;
        cycle();
        flush = 1'b0;
        cyc   = 0;
        while (!(m_sweep && m_sidx == 17) && cyc < 100) begin
            cycle();
            cyc++;
        end
        check_eq("mid_idx17", wr_idx, 17);
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        for (int c = 0; c < TS + 10; c++) begin
            fb_valid = '1;
            rand_data();
            cycle();
        end

        // Random traffic with occasional flush and reset.
        for (int c = 0; c < 400; c++) begin
            fb_valid = NP'($urandom);
            wr_ready = ($urandom_range(0, 9) < 7);
            flush    = ($urandom_range(0, 99) < 3);
            rst      = ($urandom_range(0, 199) != 0);
            rand_data();
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_targ_pred_upd_ctrl
`default_nettype wire
